// File: rtl/eflash_pkg.sv
// rtl/eflash_pkg.sv - shared PIM mode codes, input buffer states and fill capacities
package eflash_pkg;

    localparam logic [2:0] PIM_MODE_NONE     = 3'b000;
    localparam logic [2:0] PIM_MODE_PARALLEL = 3'b101;
    localparam logic [2:0] PIM_MODE_RBR      = 3'b110;

    localparam int unsigned CAP_PAR_DEFAULT = 16;
    localparam int unsigned CAP_RBR_DEFAULT = 2;

    localparam int unsigned IBUF_ENTRIES = 256;
    localparam int unsigned IBUF_LANES   = 16;

    typedef enum logic [1:0] {
        IBUF_EMPTY = 2'd0,
        IBUF_FILL  = 2'd1,
        IBUF_FULL  = 2'd2,
        IBUF_BUSY  = 2'd3
    } ibuf_state_e;

    function automatic logic is_fill_mode(input logic [2:0] mode);
        return (mode == PIM_MODE_PARALLEL) || (mode == PIM_MODE_RBR);
    endfunction

endpackage

// File: rtl/eflash_input_buffer.sv
// rtl/eflash_input_buffer.sv - word-wide fill buffer feeding 256 x 2-bit PIM inputs to the column driver
module eflash_input_buffer
    import eflash_pkg::*;
#(
    parameter int unsigned CAP_PAR = CAP_PAR_DEFAULT,
    parameter int unsigned CAP_RBR = CAP_RBR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [2:0]  pim_mode_i,
    input  logic        pim_en_i,
    input  logic [3:0]  exec_cnt_i,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    output logic [1:0]  input_data_o [0:IBUF_ENTRIES-1],
    output logic        buf_full_o,
    output logic [4:0]  word_cnt_o
);

    localparam logic [4:0] CAP_PAR_W = 5'(CAP_PAR);
    localparam logic [4:0] CAP_RBR_W = 5'(CAP_RBR);

    ibuf_state_e state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  data_q [0:IBUF_ENTRIES-1];
    logic [1:0]  data_d [0:IBUF_ENTRIES-1];

    logic        wr_ready;
    logic        accept;
    logic [2:0]  fill_mode;
    logic [4:0]  capacity;

    always_comb begin
        wr_ready = 1'b0;
        case (state_q)
            IBUF_EMPTY: wr_ready = is_fill_mode(pim_mode_i);
            IBUF_FILL:  wr_ready = 1'b1;
            default:    wr_ready = 1'b0;
        endcase
    end

    // A flush in the same cycle as a write discards that write entirely.
    assign accept = wr_valid_i && wr_ready && !clear_i;

    // The live mode only matters for the word that opens a fill; afterwards the latched copy rules.
    assign fill_mode = (state_q == IBUF_EMPTY) ? pim_mode_i : mode_q;
    assign capacity  = (fill_mode == PIM_MODE_RBR) ? CAP_RBR_W : CAP_PAR_W;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = IBUF_EMPTY;
            mode_d  = PIM_MODE_NONE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                IBUF_EMPTY: begin
                    if (accept) begin
                        mode_d  = pim_mode_i;
                        cnt_d   = cnt_q + 5'd1;
                        state_d = (cnt_d == capacity) ? IBUF_FULL : IBUF_FILL;
                    end
                end
                IBUF_FILL: begin
                    if (accept) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_d == capacity) begin
                            state_d = IBUF_FULL;
                        end
                    end
                end
                IBUF_FULL: begin
                    if (pim_en_i && (exec_cnt_i != 4'd0)) begin
                        state_d = IBUF_BUSY;
                    end
                end
                IBUF_BUSY: begin
                    if (!pim_en_i || (exec_cnt_i == 4'd0)) begin
                        state_d = IBUF_EMPTY;
                        cnt_d   = 5'd0;
                    end
                end
                default: begin
                    state_d = IBUF_EMPTY;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    // Word k lands in entries 16k..16k+15; untouched entries keep their previous contents.
    always_comb begin
        for (int i = 0; i < IBUF_ENTRIES; i++) begin
            data_d[i] = clear_i ? 2'b00 : data_q[i];
        end
        if (accept) begin
            for (int j = 0; j < IBUF_LANES; j++) begin
                data_d[{cnt_q[3:0], 4'(j)}] = wr_data_i[2*j +: 2];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IBUF_EMPTY;
            mode_q  <= PIM_MODE_NONE;
            cnt_q   <= 5'd0;
            for (int i = 0; i < IBUF_ENTRIES; i++) begin
                data_q[i] <= 2'b00;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < IBUF_ENTRIES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign wr_ready_o   = wr_ready;
    assign buf_full_o   = (state_q == IBUF_FULL) || (state_q == IBUF_BUSY);
    assign word_cnt_o   = cnt_q;
    assign input_data_o = data_q;

endmodule

// File: tb/tb_eflash_input_buffer.sv
// tb/tb_eflash_input_buffer.sv - randomized self-checking bench for eflash_input_buffer
module tb_eflash_input_buffer;

    localparam int CAP_P = 16;
    localparam int CAP_R = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [2:0]  pim_mode_i;
    logic        pim_en_i;
    logic [3:0]  exec_cnt_i;
    logic        wr_valid_i;
    logic [31:0] wr_data_i;
    logic        wr_ready_o;
    logic [1:0]  input_data_o [0:255];
    logic        buf_full_o;
    logic [4:0]  word_cnt_o;

    logic [1:0]  exp_data [0:255];
    logic [1:0]  snap [0:255];
    int          exp_cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk_i = ~clk_i;

    eflash_input_buffer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .pim_mode_i   (pim_mode_i),
        .pim_en_i     (pim_en_i),
        .exec_cnt_i   (exec_cnt_i),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .input_data_o (input_data_o),
        .buf_full_o   (buf_full_o),
        .word_cnt_o   (word_cnt_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int data_diffs();
        int d = 0;
        for (int i = 0; i < 256; i++) if (input_data_o[i] !== exp_data[i]) d++;
        return d;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 256; i++) exp_data[i] = 2'b00;
        exp_cnt = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        wr_valid_i = 1'b1;
        wr_data_i  = w;
        tick();
        wr_valid_i = 1'b0;
        for (int j = 0; j < 16; j++) exp_data[16*exp_cnt + j] = w[2*j +: 2];
        exp_cnt++;
    endtask

    task automatic fill_random(input logic [2:0] mode, input int n);
        pim_mode_i = mode;
        for (int k = 0; k < n; k++) push_word($urandom);
    endtask

    task automatic to_empty_keep();
        pim_en_i   = 1'b1;
        exec_cnt_i = 4'($urandom_range(1, 15));
        tick();
        exec_cnt_i = 4'd0;
        tick();
        pim_en_i = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic flush();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_zero();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; pim_mode_i = 3'b000; pim_en_i = 1'b0;
        exec_cnt_i = 4'd0; wr_valid_i = 1'b0; wr_data_i = 32'h0;
        model_zero();
        #1;
        tick(); tick();
        n_checks++; if (word_cnt_o !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", word_cnt_o); end
        n_checks++; if (buf_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", buf_full_o); end
        n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_nomode: got %0b expected 0", wr_ready_o); end
        n_checks++; if (data_diffs() !== 0) begin n_fail++; $display("FAIL reset_data: %0d entries differ, expected 0", data_diffs()); end
        rst_ni = 1'b1;
        pim_mode_i = 3'b101;
        #1;
        n_checks++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL empty_ready_par: got %0b expected 1", wr_ready_o); end
        pim_mode_i = 3'b011;
        #1;
        n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL empty_ready_badmode: got %0b expected 0", wr_ready_o); end
    endtask

    task automatic test_parallel_fill();
        int bad;
        pim_mode_i = 3'b101;
        for (int k = 0; k < CAP_P; k++) begin
            #1;
            if (k == CAP_P - 1) begin
                n_checks++; if (buf_full_o !== 1'b0 || word_cnt_o !== 5'(k)) begin n_fail++; $display("FAIL par_before_last: full %0b cnt %0d expected 0/%0d", buf_full_o, word_cnt_o, k); end
                n_checks++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL par_ready: got %0b expected 1", wr_ready_o); end
            end
            push_word(32'hE4E4_E4E4);
        end
        n_checks++; if (buf_full_o !== 1'b1) begin n_fail++; $display("FAIL par_full: got %0b expected 1", buf_full_o); end
        n_checks++; if (word_cnt_o !== 5'd16) begin n_fail++; $display("FAIL par_cnt: got %0d expected 16", word_cnt_o); end
        n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL par_ready_full: got %0b expected 0", wr_ready_o); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (input_data_o[i] !== 2'(i % 4)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL par_pattern: %0d entries differ from 0,1,2,3 cycle", bad); end
        flush();
    endtask

    task automatic test_rbr_fill();
        int bad;
        fill_random(3'b101, CAP_P);
        to_empty_keep();
        n_checks++; if (word_cnt_o !== 5'd0 || buf_full_o !== 1'b0) begin n_fail++; $display("FAIL busy_exit: cnt %0d full %0b expected 0/0", word_cnt_o, buf_full_o); end
        n_checks++; if (data_diffs() !== 0) begin n_fail++; $display("FAIL data_retained: %0d entries differ", data_diffs()); end
        for (int i = 0; i < 256; i++) snap[i] = exp_data[i];
        pim_mode_i = 3'b110;
        push_word(32'hFFFF_FFFF);
        n_checks++; if (buf_full_o !== 1'b0 || word_cnt_o !== 5'd1) begin n_fail++; $display("FAIL rbr_mid: full %0b cnt %0d expected 0/1", buf_full_o, word_cnt_o); end
        push_word(32'h0000_0000);
        n_checks++; if (buf_full_o !== 1'b1 || word_cnt_o !== 5'd2) begin n_fail++; $display("FAIL rbr_full: full %0b cnt %0d expected 1/2", buf_full_o, word_cnt_o); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (input_data_o[i] !== 2'd3) bad++;
        for (int i = 16; i < 32; i++) if (input_data_o[i] !== 2'd0) bad++;
        for (int i = 32; i < 256; i++) if (input_data_o[i] !== snap[i]) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rbr_entries: %0d entries wrong", bad); end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 4; c++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = $urandom;
            #1;
            n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b expected 0", wr_ready_o); end
            tick();
        end
        wr_valid_i = 1'b0;
        n_checks++; if (data_diffs() !== 0 || word_cnt_o !== 5'd2) begin n_fail++; $display("FAIL bp_hold: %0d diffs cnt %0d expected 0/2", data_diffs(), word_cnt_o); end
        pim_en_i = 1'b1; exec_cnt_i = 4'd12;
        tick();
        n_checks++; if (buf_full_o !== 1'b1 || wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL busy_enter: full %0b ready %0b expected 1/0", buf_full_o, wr_ready_o); end
        for (int c = 0; c < 3; c++) begin
            exec_cnt_i = 4'($urandom_range(1, 15));
            pim_mode_i = 3'($urandom);
            wr_valid_i = 1'b1;
            wr_data_i  = $urandom;
            tick();
        end
        wr_valid_i = 1'b0;
        pim_mode_i = 3'b110;
        n_checks++; if (buf_full_o !== 1'b1 || data_diffs() !== 0 || word_cnt_o !== 5'd2) begin n_fail++; $display("FAIL busy_hold: full %0b diffs %0d cnt %0d expected 1/0/2", buf_full_o, data_diffs(), word_cnt_o); end
        exec_cnt_i = 4'd0;
        tick();
        pim_en_i = 1'b0;
        exp_cnt = 0;
        n_checks++; if (buf_full_o !== 1'b0 || word_cnt_o !== 5'd0) begin n_fail++; $display("FAIL busy_done: full %0b cnt %0d expected 0/0", buf_full_o, word_cnt_o); end
        n_checks++; if (data_diffs() !== 0) begin n_fail++; $display("FAIL busy_done_data: %0d entries differ", data_diffs()); end
    endtask

    task automatic test_clear_priority();
        fill_random(3'b101, 5);
        n_checks++; if (word_cnt_o !== 5'd5) begin n_fail++; $display("FAIL clr_pre_cnt: got %0d expected 5", word_cnt_o); end
        clear_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = $urandom | 32'h1;
        tick();
        clear_i = 1'b0; wr_valid_i = 1'b0;
        model_zero();
        n_checks++; if (word_cnt_o !== 5'd0 || buf_full_o !== 1'b0) begin n_fail++; $display("FAIL clr_state: cnt %0d full %0b expected 0/0", word_cnt_o, buf_full_o); end
        n_checks++; if (data_diffs() !== 0) begin n_fail++; $display("FAIL clr_data: %0d entries nonzero", data_diffs()); end
        fill_random(3'b110, CAP_R);
        flush();
        n_checks++; if (buf_full_o !== 1'b0 || data_diffs() !== 0) begin n_fail++; $display("FAIL clr_from_full: full %0b diffs %0d expected 0/0", buf_full_o, data_diffs()); end
    endtask

    task automatic test_mode_latch();
        pim_mode_i = 3'b101;
        push_word($urandom);
        pim_mode_i = 3'b110;
        push_word($urandom);
        n_checks++; if (buf_full_o !== 1'b0 || word_cnt_o !== 5'd2) begin n_fail++; $display("FAIL latch_2: full %0b cnt %0d expected 0/2", buf_full_o, word_cnt_o); end
        for (int k = 2; k < CAP_P; k++) push_word($urandom);
        n_checks++; if (buf_full_o !== 1'b1 || word_cnt_o !== 5'd16) begin n_fail++; $display("FAIL latch_16: full %0b cnt %0d expected 1/16", buf_full_o, word_cnt_o); end
        n_checks++; if (data_diffs() !== 0) begin n_fail++; $display("FAIL latch_data: %0d entries differ", data_diffs()); end
        flush();
    endtask

    task automatic test_async_reset();
        fill_random(3'b110, CAP_R);
        pim_en_i = 1'b1; exec_cnt_i = 4'd7;
        tick();
        n_checks++; if (buf_full_o !== 1'b1) begin n_fail++; $display("FAIL ar_busy: full %0b expected 1", buf_full_o); end
        #3;
        rst_ni = 1'b0;
        #1;
        model_zero();
        n_checks++; if (buf_full_o !== 1'b0 || word_cnt_o !== 5'd0) begin n_fail++; $display("FAIL ar_now: full %0b cnt %0d expected 0/0", buf_full_o, word_cnt_o); end
        n_checks++; if (data_diffs() !== 0) begin n_fail++; $display("FAIL ar_data: %0d entries nonzero", data_diffs()); end
        pim_en_i = 1'b0; exec_cnt_i = 4'd0;
        wr_valid_i = 1'b1; wr_data_i = $urandom;
        tick(); tick();
        rst_ni = 1'b1;
        pim_mode_i = 3'b000;
        tick();
        wr_valid_i = 1'b0;
        n_checks++; if (word_cnt_o !== 5'd0 || data_diffs() !== 0) begin n_fail++; $display("FAIL ar_release: cnt %0d diffs %0d expected 0/0", word_cnt_o, data_diffs()); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] m;
        int cap;
        for (int it = 0; it < 8; it++) begin
            m   = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b110;
            cap = (m == 3'b101) ? CAP_P : CAP_R;
            pim_mode_i = m;
            for (int k = 0; k < cap; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wr_data_i = $urandom;
                    tick();
                    n_checks++; if (word_cnt_o !== 5'(k)) begin n_fail++; $display("FAIL b2b_idle it%0d: cnt %0d expected %0d", it, word_cnt_o, k); end
                end
                push_word($urandom);
            end
            n_checks++; if (buf_full_o !== 1'b1 || word_cnt_o !== 5'(cap)) begin n_fail++; $display("FAIL b2b_full it%0d: full %0b cnt %0d expected 1/%0d", it, buf_full_o, word_cnt_o, cap); end
            n_checks++; if (data_diffs() !== 0) begin n_fail++; $display("FAIL b2b_data it%0d: %0d entries differ", it, data_diffs()); end
            if ($urandom_range(0, 1) == 1) to_empty_keep();
            else flush();
            n_checks++; if (word_cnt_o !== 5'd0 || buf_full_o !== 1'b0 || data_diffs() !== 0) begin n_fail++; $display("FAIL b2b_exit it%0d: cnt %0d full %0b diffs %0d expected 0/0/0", it, word_cnt_o, buf_full_o, data_diffs()); end
        end
    endtask

    initial begin
        test_reset();
        test_parallel_fill();
        test_rbr_fill();
        test_backpressure();
        test_clear_priority();
        test_mode_latch();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
